// File: rtl/ysyx_22040175_pipe_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath and its hazard/sequencing controller.
// master = pipeline datapath side, slave = controller side.
interface ysyx_22040175_pipe_ctrl_if;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        ex_reg_wen;
    logic [4:0]  ex_reg_waddr;
    logic        ex_is_load;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ready;
    logic        wb_ebreak;

    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        ex_mem_stall;
    logic        mem_wb_flush;
    logic        halted;
    logic        mem_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_memwait_cycles;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_reg_wen, ex_reg_waddr, ex_is_load, ex_redirect,
               mem_req, mem_ready, wb_ebreak,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, halted, mem_timeout,
               perf_stall_cycles, perf_flush_cnt, perf_memwait_cycles
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               ex_reg_wen, ex_reg_waddr, ex_is_load, ex_redirect,
               mem_req, mem_ready, wb_ebreak,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, halted, mem_timeout,
               perf_stall_cycles, perf_flush_cnt, perf_memwait_cycles
    );
endinterface

// File: rtl/ysyx_22040175_pipe_ctrl.sv
// Stall/flush controller for the IF-ID-EX-MEM-WB pipeline: load-use, EX redirect, MEM waits, ebreak halt.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module ysyx_22040175_pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22040175_pipe_ctrl_if.slave       bus
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW:0] TMO = MEM_TIMEOUT[CW:0];

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    logic          load_use;
    logic          mem_wait_now;
    logic          halt_now;
    logic          redirect_now;
    logic [CW:0]   cnt_inc;
    logic          tmo_hit;

    always_comb begin
        load_use = bus.ex_is_load && bus.ex_reg_wen && (bus.ex_reg_waddr != 5'd0) &&
                   ((bus.id_rs1_used && (bus.id_rs1_addr == bus.ex_reg_waddr)) ||
                    (bus.id_rs2_used && (bus.id_rs2_addr == bus.ex_reg_waddr)));
        // An ebreak retiring this cycle already presents the frozen outputs.
        halt_now     = (state == S_HALT) || bus.wb_ebreak;
        mem_wait_now = (state == S_MEM_WAIT) ||
                       ((state == S_RUN) && bus.mem_req && !bus.mem_ready);
        redirect_now = !halt_now && !mem_wait_now && bus.ex_redirect;
        cnt_inc      = {1'b0, wait_cnt} + (CW + 1)'(1);
        tmo_hit      = (state == S_MEM_WAIT) && !bus.mem_ready && (cnt_inc >= TMO);
    end

    always_comb begin
        bus.pc_stall     = 1'b0;
        bus.if_id_stall  = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_stall  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_stall = 1'b0;
        bus.mem_wb_flush = 1'b0;
        bus.halted       = 1'b0;
        if (rst) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.mem_wb_flush = 1'b1;
        end else if (halt_now) begin
            bus.pc_stall     = 1'b1;
            bus.if_id_stall  = 1'b1;
            bus.id_ex_stall  = 1'b1;
            bus.ex_mem_stall = 1'b1;
            bus.mem_wb_flush = 1'b1;
            bus.halted       = 1'b1;
        end else if (mem_wait_now) begin
            // EX is held too, so a pending redirect is simply re-presented on release.
            bus.pc_stall     = 1'b1;
            bus.if_id_stall  = 1'b1;
            bus.id_ex_stall  = 1'b1;
            bus.ex_mem_stall = 1'b1;
            bus.mem_wb_flush = 1'b1;
        end else if (bus.ex_redirect) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
        end else if (load_use) begin
            bus.pc_stall     = 1'b1;
            bus.if_id_stall  = 1'b1;
            bus.id_ex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (bus.wb_ebreak) begin
                        state <= S_HALT;
                    end else if (bus.mem_req && !bus.mem_ready) begin
                        state    <= S_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (tmo_hit) timeout_q <= 1'b1;
                    if (bus.wb_ebreak || tmo_hit) begin
                        state <= S_HALT;
                    end else if (bus.mem_ready) begin
                        state <= S_RUN;
                    end else begin
                        wait_cnt <= (cnt_inc >= TMO) ? TMO[CW-1:0] : cnt_inc[CW-1:0];
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

    assign bus.mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_memwait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
            perf_memwait_q <= '0;
        end else if (!halt_now) begin
            if (bus.pc_stall)         perf_stall_q   <= perf_stall_q + 32'd1;
            if (redirect_now)         perf_flush_q   <= perf_flush_q + 32'd1;
            if (state == S_MEM_WAIT)  perf_memwait_q <= perf_memwait_q + 32'd1;
        end
    end

    assign bus.perf_stall_cycles   = perf_stall_q;
    assign bus.perf_flush_cnt      = perf_flush_q;
    assign bus.perf_memwait_cycles = perf_memwait_q;
`else
    logic unused_perf;
    assign unused_perf             = redirect_now;
    assign bus.perf_stall_cycles   = 32'd0;
    assign bus.perf_flush_cnt      = 32'd0;
    assign bus.perf_memwait_cycles = 32'd0;
`endif
endmodule
